// File: rtl/jingle_if.sv
// Event-request and tone-output bundle between game logic and the jingle sequencer.
// master drives requests and the 1 ms tick; slave is the sequencer.
interface jingle_if;
  logic       tick_ms;
  logic [2:0] req;
  logic [3:0] tone;
  logic       enable_sound;
  logic       busy;
  logic [1:0] playing_id;
  logic       done;

  modport master (
    output tick_ms, req,
    input  tone, enable_sound, busy, playing_id, done
  );

  modport slave (
    input  tick_ms, req,
    output tone, enable_sound, busy, playing_id, done
  );
endinterface

// File: rtl/jingle_sequencer.sv
// Prioritised jingle scheduler: latches event requests, picks the highest one and steps
// through its built-in note list, driving tone/enable_sound for the tone decoder.
module jingle_sequencer #(
  parameter int unsigned NOTE_TICKS = 100,
  parameter int unsigned GAP_TICKS  = 10
) (
  input logic      clk,
  input logic      reset,
  jingle_if.slave  bus
);

  localparam int unsigned MaxCnt = (7 * NOTE_TICKS > GAP_TICKS) ? 7 * NOTE_TICKS : GAP_TICKS;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StPlay, StGap} state_e;

  state_e          state_q, state_d;
  logic [2:0]      pend_q, pend_d;
  logic [1:0]      id_q, id_d;
  logic [2:0]      addr_q, addr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      tone_q, tone_d;
  logic            en_q, en_d;
  logic            done_q, done_d;

  logic [1:0] win, f_id;
  logic [2:0] win_oh, pend_clr, f_addr;
  logic       preempt, fetch, f_end;
  logic [6:0] entry;

  // Entry = {tone, dur}; dur == 0 marks the end of a jingle.
  function automatic logic [6:0] rom(input logic [1:0] id, input logic [2:0] a);
    logic [6:0] e;
    case ({id, a})
      5'b00_000: e = {4'd9,  3'd1};
      5'b00_001: e = {4'd5,  3'd1};
      5'b00_010: e = {4'd0,  3'd2};
      5'b01_000: e = {4'd0,  3'd1};
      5'b01_001: e = {4'd4,  3'd1};
      5'b01_010: e = {4'd7,  3'd1};
      5'b01_011: e = {4'd11, 3'd3};
      5'b10_000: e = {4'd7,  3'd2};
      5'b10_001: e = {4'd6,  3'd2};
      5'b10_010: e = {4'd5,  3'd2};
      5'b10_011: e = {4'd4,  3'd4};
      default:   e = '0;
    endcase
    return e;
  endfunction

  always_comb begin
    if (pend_q[2])      win = 2'd2;
    else if (pend_q[1]) win = 2'd1;
    else                win = 2'd0;
    win_oh = 3'b001 << win;
    case (id_q)
      2'd0:    preempt = |pend_q[2:1];
      2'd1:    preempt = pend_q[2];
      default: preempt = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    tone_d   = tone_q;
    en_d     = en_q;
    done_d   = 1'b0;
    pend_clr = '0;
    fetch    = 1'b0;
    f_end    = 1'b0;
    f_id     = id_q;
    f_addr   = addr_q;

    unique case (state_q)
      StIdle: if (pend_q != '0) state_d = StLoad;
      StLoad: begin
        f_id     = win;
        f_addr   = '0;
        pend_clr = win_oh;
        fetch    = 1'b1;
      end
      StPlay, StGap: begin
        if (preempt) begin
          en_d    = 1'b0;
          state_d = StLoad;
        end else if (bus.tick_ms) begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            en_d = 1'b0;
            if (state_q == StPlay && GAP_TICKS != 0) begin
              state_d = StGap;
              cnt_d   = CntW'(GAP_TICKS);
            end else if (addr_q == 3'd7) begin
              f_end = 1'b1;
            end else begin
              fetch  = 1'b1;
              f_addr = addr_q + 3'd1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Loading an entry starts its note immediately, so gaps are exactly GAP_TICKS long.
    entry = rom(f_id, f_addr);
    if (fetch && entry[2:0] == 3'd0) f_end = 1'b1;

    if (f_end) begin
      done_d  = 1'b1;
      en_d    = 1'b0;
      state_d = StIdle;
      id_d    = '0;
      addr_d  = '0;
      cnt_d   = '0;
    end else if (fetch) begin
      tone_d  = entry[6:3];
      en_d    = 1'b1;
      cnt_d   = CntW'(entry[2:0]) * CntW'(NOTE_TICKS);
      id_d    = f_id;
      addr_d  = f_addr;
      state_d = StPlay;
    end

    // A request arriving in the selection cycle re-arms the bit.
    pend_d = (pend_q & ~pend_clr) | bus.req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pend_q  <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      tone_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      tone_q  <= tone_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign bus.tone         = tone_q;
  assign bus.enable_sound = en_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.playing_id   = id_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_jingle_sequencer.sv
// Randomised and directed bench for jingle_sequencer against a note-list scheduler model.
module tb_jingle_sequencer;
  localparam int NT = 2;
  localparam int GT = 1;

  logic clk = 1'b0;
  logic reset;
  jingle_if bus ();

  jingle_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int jt[3][8] = '{'{9, 5, 0, 0, 0, 0, 0, 0},
                   '{0, 4, 7, 11, 0, 0, 0, 0},
                   '{7, 6, 5, 4, 0, 0, 0, 0}};
  int jd[3][8] = '{'{1, 1, 2, 0, 0, 0, 0, 0},
                   '{1, 1, 1, 3, 0, 0, 0, 0},
                   '{2, 2, 2, 4, 0, 0, 0, 0}};

  // Model: a jingle is a note list; each note sounds for dur*NT ticks then rests GT ticks.
  int m_pend = 0, m_id = 0, m_idx = 0, m_left = 0, m_tone = 0;
  bit m_busy = 0, m_load = 0, m_note = 0, m_en = 0, m_done = 0;

  function automatic int highest(input int p);
    if (p & 4) return 2;
    if (p & 2) return 1;
    return 0;
  endfunction

  function void start_entry();
    if (m_idx > 7 || jd[m_id][m_idx] == 0) begin
      m_done = 1; m_busy = 0; m_load = 0; m_note = 0; m_en = 0; m_id = 0;
    end else begin
      m_tone = jt[m_id][m_idx]; m_en = 1; m_note = 1; m_load = 0;
      m_left = jd[m_id][m_idx] * NT;
    end
  endfunction

  function void model_step(input logic [2:0] r, input logic t, input logic rs);
    int np;
    m_done = 0;
    if (rs) begin
      m_pend = 0; m_id = 0; m_idx = 0; m_left = 0; m_tone = 0;
      m_busy = 0; m_load = 0; m_note = 0; m_en = 0;
      return;
    end
    np = m_pend;
    if (!m_busy) begin
      if (m_pend != 0) begin m_busy = 1; m_load = 1; end
    end else if (m_load) begin
      m_id = highest(m_pend);
      np = np & ~(1 << m_id);
      m_idx = 0;
      start_entry();
    end else if ((m_pend >> (m_id + 1)) != 0) begin
      m_en = 0; m_note = 0; m_load = 1;
    end else if (t) begin
      m_left--;
      if (m_left == 0) begin
        if (m_note && GT > 0) begin
          m_en = 0; m_note = 0; m_left = GT;
        end else begin
          m_en = 0; m_note = 0; m_idx++;
          start_entry();
        end
      end
    end
    m_pend = np | int'(r);
  endfunction

  function automatic logic [8:0] dut_vec();
    return {bus.tone, bus.enable_sound, bus.busy, bus.playing_id, bus.done};
  endfunction

  function automatic logic [8:0] exp_vec();
    return {4'(m_tone), m_en, m_busy, 2'(m_id), m_done};
  endfunction

  task automatic cycle(input logic [2:0] r, input logic t, input logic rs);
    bus.req = r; bus.tick_ms = t; reset = rs;
    @(posedge clk);
    model_step(r, t, rs);
    #1;
    bus.req = 3'b000; reset = 1'b0;
  endtask

  task automatic test_reset();
    cycle(3'b000, 1'b1, 1'b1);
    cycle(3'b000, 1'b1, 1'b1);
    tests++;
    if (dut_vec() !== 9'd0) begin
      fails++; $display("FAIL reset got %h want %h", dut_vec(), 9'd0);
    end
  endtask

  task automatic test_single();
    int en_cnt = 0, done_cnt = 0;
    cycle(3'b001, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(3'b000, 1'b1, 1'b0);
      en_cnt += int'(bus.enable_sound);
      done_cnt += int'(bus.done);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL single c%0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    tests++;
    if (en_cnt != 8 || done_cnt != 1 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL single_sum got en=%0d done=%0d want en=8 done=1", en_cnt, done_cnt);
    end
  endtask

  task automatic test_all_three();
    int done_cnt = 0;
    cycle(3'b111, 1'b1, 1'b0);
    for (int i = 0; i < 110; i++) begin
      cycle(3'b000, 1'b1, 1'b0);
      done_cnt += int'(bus.done);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL all3 c%0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    tests++;
    if (done_cnt != 3) begin
      fails++; $display("FAIL all3_done got %0d want 3", done_cnt);
    end
  endtask

  task automatic test_preempt();
    int done_cnt = 0;
    bit hit = 0;
    cycle(3'b001, 1'b1, 1'b0);
    for (int i = 0; i < 30 && !hit; i++) begin
      cycle(3'b000, 1'b1, 1'b0);
      if (m_idx == 1 && m_en) hit = 1;
    end
    tests++;
    if (!hit) begin fails++; $display("FAIL preempt_wait got none want second note"); end
    cycle(3'b100, 1'b1, 1'b0);
    cycle(3'b000, 1'b1, 1'b0);
    tests++;
    if (bus.enable_sound !== 1'b0) begin
      fails++; $display("FAIL preempt_mute got %b want 0", bus.enable_sound);
    end
    cycle(3'b000, 1'b1, 1'b0);
    tests++;
    if (bus.tone !== 4'd7 || bus.enable_sound !== 1'b1) begin
      fails++; $display("FAIL preempt_j2 got tone %0d en %b want 7 1", bus.tone, bus.enable_sound);
    end
    for (int i = 0; i < 50; i++) begin
      cycle(3'b000, 1'b1, 1'b0);
      done_cnt += int'(bus.done);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL preempt c%0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    tests++;
    if (done_cnt != 1 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL preempt_done got %0d busy %b want 1 0", done_cnt, bus.busy);
    end
  endtask

  task automatic test_low_then_high(input string name, input logic [2:0] a, input logic [2:0] b);
    int done_cnt = 0;
    cycle(a, 1'b1, 1'b0);
    for (int i = 0; i < 120; i++) begin
      cycle((i == 8) ? b : 3'b000, 1'b1, 1'b0);
      done_cnt += int'(bus.done);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL %s c%0d got %h want %h", name, i, dut_vec(), exp_vec());
      end
    end
    tests++;
    if (done_cnt != 2) begin
      fails++; $display("FAIL %s_done got %0d want 2", name, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    cycle(3'b010, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(3'b000, 1'b1, 1'b0);
    cycle(3'b001, 1'b1, 1'b0);
    cycle(3'b000, 1'b1, 1'b0);
    cycle(3'b000, 1'b1, 1'b1);
    tests++;
    if (dut_vec() !== 9'd0) begin
      fails++; $display("FAIL reset_mid got %h want %h", dut_vec(), 9'd0);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(3'b000, 1'b1, 1'b0);
      tests++;
      if (bus.busy !== 1'b0 || dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL reset_lost c%0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_slow_tick();
    int done_cnt = 0;
    cycle(3'b001, 1'b0, 1'b0);
    for (int i = 0; i < 120; i++) begin
      cycle(3'b000, (i % 5) == 0, 1'b0);
      done_cnt += int'(bus.done);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL slow c%0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL slow_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_no_tick();
    bit up = 0;
    cycle(3'b001, 1'b1, 1'b0);
    for (int i = 0; i < 10 && !up; i++) begin
      cycle(3'b000, 1'b1, 1'b0);
      up = bus.enable_sound;
    end
    for (int i = 0; i < 50; i++) begin
      cycle(3'b000, 1'b0, 1'b0);
      tests++;
      if (bus.tone !== 4'd9 || bus.enable_sound !== 1'b1) begin
        fails++; $display("FAIL hold c%0d got tone %0d en %b want 9 1", i, bus.tone,
                          bus.enable_sound);
      end
    end
    for (int i = 0; i < 30; i++) cycle(3'b000, 1'b1, 1'b0);
    tests++;
    if (dut_vec() !== exp_vec() || bus.busy !== 1'b0) begin
      fails++; $display("FAIL hold_end got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [2:0] r;
    for (int i = 0; i < 3000; i++) begin
      r = {$urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0};
      cycle(r, $urandom_range(0, 2) != 0, $urandom_range(0, 599) == 0);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL random c%0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.req = 3'b000;
    bus.tick_ms = 1'b0;
    reset = 1'b1;
    test_reset();
    test_single();
    test_all_three();
    test_preempt();
    test_low_then_high("lowprio", 3'b100, 3'b001);
    test_low_then_high("repeat", 3'b010, 3'b010);
    test_reset_mid();
    test_slow_tick();
    test_no_tick();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
